fwd_core_tx_4x4: RTL and testbench

//  - Forward 4x4 integer core transform stage, Y = C*X*C^T, C = {{1,1,1,1},{2,1,-1,-2},{1,-1,-1,1},{1,-2,2,-1}}.
//  - Sits directly upstream of the 4x4 quantiser.
//  - Accepts one residual row per beat (4 beats per block).
//  - Presents all 16 coefficients in parallel, held until consumed, on the array the quantiser samples.

---
 rtl/fwd_core_tx_4x4_if.sv | 27 ++
 rtl/fwd_core_tx_4x4.sv | 187 ++++++++++++++++++
 tb/tb_fwd_core_tx_4x4.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_core_tx_4x4_if.sv
// Handshake and coefficient bus for the forward 4x4 core transform stage.
// The residual row input and the parallel coefficient output are bundled here.
// The master side is the environment: it feeds rows and consumes coefficient blocks.
// The slave side is the transform stage itself.
interface fwd_core_tx_4x4_if #(
    parameter int IN_WIDTH  = 9,
    parameter int OUT_WIDTH = 16
);
    logic                        in_valid;
    logic                        in_ready;
    logic                        in_mode;
    logic [4*IN_WIDTH-1:0]       in_row;
    logic                        out_valid;
    logic                        out_ready;
    logic                        out_mode;
    logic signed [OUT_WIDTH-1:0] coeff [16];

    modport master (
        output in_valid, in_mode, in_row, out_ready,
        input  in_ready, out_valid, out_mode, coeff
    );

    modport slave (
        input  in_valid, in_mode, in_row, out_ready,
        output in_ready, out_valid, out_mode, coeff
    );
endinterface

// File: rtl/fwd_core_tx_4x4.sv
// Forward 4x4 integer core transform, Y = C*X*C^T.
// Rows arrive one per beat and go through the row butterfly into a row buffer.
// One COL cycle then runs the column butterfly over the whole buffer.
// The 16 coefficients are held on the bus until the quantiser takes them.
// Optional feature macro: FWD_TX_HADAMARD_EN adds a 'hadamard' input.
// That input selects the 4x4 Hadamard transform with a final >>>1 for luma DC blocks.
module fwd_core_tx_4x4 #(
    parameter int IN_WIDTH  = 9,
    parameter int OUT_WIDTH = 16
) (
    input  logic               clk,
    input  logic               reset,
`ifdef FWD_TX_HADAMARD_EN
    input  logic               hadamard,
`endif
    fwd_core_tx_4x4_if.slave   bus
);
    // The row-stage gain is at most 6, so three extra bits hold any row result exactly.
    localparam int RW = IN_WIDTH + 3;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_COL  = 2'd1;
    localparam logic [1:0] ST_OUT  = 2'd2;

    typedef logic signed [RW-1:0]        row_t;
    typedef logic signed [OUT_WIDTH-1:0] coeff_t;

    logic [1:0]             r_state;
    logic [1:0]             r_rowCnt;
    logic                   r_mode;
    logic                   r_outValid;
    logic                   r_outMode;
    row_t                   r_rowBuf [4][4];
    coeff_t                 r_coeff  [16];
`ifdef FWD_TX_HADAMARD_EN
    logic                   r_had;
`endif

    logic                   w_inReady;
    logic                   w_beat;
    logic                   w_rowHad;
    logic                   w_colHad;
    row_t                   w_rowIn  [4];
    logic [4*RW-1:0]        w_rowRes;
    logic [4*OUT_WIDTH-1:0] w_colVec [4];
    coeff_t                 w_colRes [16];

    // Row-width butterfly. had=1 gives the Hadamard basis; had=0 gives the core transform.
    function automatic logic [4*RW-1:0] rowButterfly(input row_t a0, input row_t a1,
                                                     input row_t a2, input row_t a3,
                                                     input logic had);
        row_t s0, s1, d0, d1, r0, r1, r2, r3;
        s0 = a0 + a3;
        s1 = a1 + a2;
        d0 = a0 - a3;
        d1 = a1 - a2;
        r0 = s0 + s1;
        r2 = s0 - s1;
        if (had) begin
            r1 = d0 + d1;
            r3 = d0 - d1;
        end else begin
            r1 = (d0 <<< 1) + d1;
            r3 = d0 - (d1 <<< 1);
        end
        return {r3, r2, r1, r0};
    endfunction

    // Coefficient-width butterfly. It is the same arithmetic, but it is wide enough for the full gain of 36.
    function automatic logic [4*OUT_WIDTH-1:0] colButterfly(input coeff_t a0, input coeff_t a1,
                                                            input coeff_t a2, input coeff_t a3,
                                                            input logic had);
        coeff_t s0, s1, d0, d1, r0, r1, r2, r3;
        s0 = a0 + a3;
        s1 = a1 + a2;
        d0 = a0 - a3;
        d1 = a1 - a2;
        r0 = s0 + s1;
        r2 = s0 - s1;
        if (had) begin
            r1 = d0 + d1;
            r3 = d0 - d1;
        end else begin
            r1 = (d0 <<< 1) + d1;
            r3 = d0 - (d1 <<< 1);
        end
        return {r3, r2, r1, r0};
    endfunction

    assign w_inReady     = (r_state == ST_LOAD);
    assign w_beat        = bus.in_valid && w_inReady;
    assign bus.in_ready  = w_inReady;
    assign bus.out_valid = r_outValid;
    assign bus.out_mode  = r_outMode;
    assign bus.coeff     = r_coeff;

`ifdef FWD_TX_HADAMARD_EN
    // Row 0 sees the live select; rows 1..3 and the column pass use the value latched on beat 0.
    assign w_rowHad = (r_rowCnt == 2'd0) ? hadamard : r_had;
    assign w_colHad = r_had;
`else
    assign w_rowHad = 1'b0;
    assign w_colHad = 1'b0;
`endif

    // Row stage: sign-extend the incoming samples and run the row butterfly.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_rowIn[j] = RW'($signed(bus.in_row[j*IN_WIDTH +: IN_WIDTH]));
        end
        w_rowRes = rowButterfly(w_rowIn[0], w_rowIn[1], w_rowIn[2], w_rowIn[3], w_rowHad);
    end

    // Column stage: butterfly each buffer column and apply the Hadamard halving when selected.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            w_colVec[j] = colButterfly(OUT_WIDTH'(r_rowBuf[0][j]), OUT_WIDTH'(r_rowBuf[1][j]),
                                       OUT_WIDTH'(r_rowBuf[2][j]), OUT_WIDTH'(r_rowBuf[3][j]),
                                       w_colHad);
        end
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                w_colRes[4*i+j] = $signed(w_colVec[j][i*OUT_WIDTH +: OUT_WIDTH]);
                if (w_colHad) begin
                    w_colRes[4*i+j] = w_colRes[4*i+j] >>> 1;
                end
            end
        end
    end

    // Control FSM: LOAD collects four rows, COL registers the block, OUT waits for the consumer.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_LOAD;
            r_rowCnt   <= 2'd0;
            r_mode     <= 1'b0;
            r_outValid <= 1'b0;
            r_outMode  <= 1'b0;
`ifdef FWD_TX_HADAMARD_EN
            r_had      <= 1'b0;
`endif
            for (int k = 0; k < 4; k++) begin
                for (int j = 0; j < 4; j++) begin
                    r_rowBuf[k][j] <= '0;
                end
            end
            for (int k = 0; k < 16; k++) begin
                r_coeff[k] <= '0;
            end
        end else begin
            case (r_state)
                ST_LOAD: begin
                    if (w_beat) begin
                        for (int j = 0; j < 4; j++) begin
                            r_rowBuf[r_rowCnt][j] <= $signed(w_rowRes[j*RW +: RW]);
                        end
                        if (r_rowCnt == 2'd0) begin
                            r_mode <= bus.in_mode;
`ifdef FWD_TX_HADAMARD_EN
                            r_had  <= hadamard;
`endif
                        end
                        r_rowCnt <= r_rowCnt + 2'd1;
                        if (r_rowCnt == 2'd3) begin
                            r_state <= ST_COL;
                        end
                    end
                end
                ST_COL: begin
                    r_coeff    <= w_colRes;
                    r_outValid <= 1'b1;
                    r_outMode  <= r_mode;
                    r_state    <= ST_OUT;
                end
                ST_OUT: begin
                    if (r_outValid && bus.out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_fwd_core_tx_4x4.sv
// Directed testbench for fwd_core_tx_4x4.
// All expected coefficients are worked out by hand from Y = C*X*C^T.
// The Hadamard cases are compiled in only when FWD_TX_HADAMARD_EN is defined.
module tb_fwd_core_tx_4x4;
    localparam int IW = 9;
    localparam int OW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
`ifdef FWD_TX_HADAMARD_EN
    logic hadamard = 1'b0;
    logic blockHad = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int expCoeff [16];

    fwd_core_tx_4x4_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    fwd_core_tx_4x4 #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef FWD_TX_HADAMARD_EN
        .hadamard (hadamard),
`endif
        .bus      (bus)
    );

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    // Pack four samples into a row, with x[j] placed at bits [j*IW +: IW].
    function automatic logic [4*IW-1:0] packRow(input int a, input int b, input int c, input int d);
        return {IW'(d), IW'(c), IW'(b), IW'(a)};
    endfunction

    // Compare one observed value against its expected value, and count and report any failure.
    task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                               input logic signed [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Send nBeats rows starting at a quiet point.
    // Mode is given on beat 0 only; later beats carry the opposite value, which must be ignored.
    task automatic applyStimulus(input logic [4*IW-1:0] r0, input logic [4*IW-1:0] r1,
                                 input logic [4*IW-1:0] r2, input logic [4*IW-1:0] r3,
                                 input logic mode, input int nBeats);
        logic [4*IW-1:0] rows [4];
        rows = '{r0, r1, r2, r3};
        for (int b = 0; b < nBeats; b++) begin
            bus.in_valid = 1'b1;
            bus.in_row   = rows[b];
            bus.in_mode  = (b == 0) ? mode : ~mode;
`ifdef FWD_TX_HADAMARD_EN
            hadamard     = (b == 0) ? blockHad : ~blockHad;
`endif
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        bus.in_row   = '0;
    endtask

    // out_valid must be low during the COL cycle and high in the cycle after it.
    task automatic awaitBlock(input string tag);
        @(negedge clk);
        checkOutput({tag, "_lat_col"}, bus.out_valid, 0);
        @(negedge clk);
        checkOutput({tag, "_lat_valid"}, bus.out_valid, 1);
    endtask

    // Compare all 16 coefficients against expCoeff.
    task automatic checkCoeffs(input string tag);
        for (int i = 0; i < 16; i++) begin
            checkOutput($sformatf("%s_c%0d", tag, i), bus.coeff[i], expCoeff[i]);
        end
    endtask

    // With out_ready high, the handshake happens on the next edge and LOAD reopens.
    task automatic releaseBlock(input string tag);
        @(negedge clk);
        checkOutput({tag, "_drop_valid"}, bus.out_valid, 0);
        checkOutput({tag, "_ready_back"}, bus.in_ready, 1);
    endtask

    task automatic setExpDc(input int dc);
        for (int i = 0; i < 16; i++) expCoeff[i] = 0;
        expCoeff[0] = dc;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_mode   = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state.
        checkOutput("rst_in_ready", bus.in_ready, 1);
        checkOutput("rst_out_valid", bus.out_valid, 0);
        checkOutput("rst_out_mode", bus.out_mode, 0);
        checkOutput("rst_coeff0", bus.coeff[0], 0);
        checkOutput("rst_coeff15", bus.coeff[15], 0);
        reset = 1'b0;

        // All-ones rows: each row gives [4,0,0,0], and column 0 gives 16.
        applyStimulus(packRow(1,1,1,1), packRow(1,1,1,1), packRow(1,1,1,1), packRow(1,1,1,1), 1'b1, 4);
        awaitBlock("ones");
        setExpDc(16);
        checkCoeffs("ones");
        checkOutput("ones_mode", bus.out_mode, 1);
        releaseBlock("ones");
        checkOutput("ones_retain_c0", bus.coeff[0], 16);

        // Impulse: Y[i][j] = c[i]*c[j] with c = {1,2,1,1}.
        applyStimulus(packRow(1,0,0,0), packRow(0,0,0,0), packRow(0,0,0,0), packRow(0,0,0,0), 1'b0, 4);
        awaitBlock("imp");
        expCoeff = '{1,2,1,1, 2,4,2,2, 1,2,1,1, 1,2,1,1};
        checkCoeffs("imp");
        checkOutput("imp_mode", bus.out_mode, 0);
        releaseBlock("imp");

        // Checkerboard +/-255: the row sums with sign pattern {+,-,+,-} are {0,2,0,6}.
        // So Y[i][j] = 255*v[i]*v[j] with v = {0,2,0,6}: 1020, 3060, 3060 and 9180.
        applyStimulus(packRow(255,-255,255,-255), packRow(-255,255,-255,255),
                      packRow(255,-255,255,-255), packRow(-255,255,-255,255), 1'b1, 4);
        awaitBlock("chk");
        expCoeff = '{0,0,0,0, 0,1020,0,3060, 0,0,0,0, 0,3060,0,9180};
        checkCoeffs("chk");
        releaseBlock("chk");

        // Most negative input everywhere: the DC term is 16*(-256).
        applyStimulus(packRow(-256,-256,-256,-256), packRow(-256,-256,-256,-256),
                      packRow(-256,-256,-256,-256), packRow(-256,-256,-256,-256), 1'b0, 4);
        awaitBlock("neg");
        setExpDc(-4096);
        checkCoeffs("neg");
        releaseBlock("neg");

        // Backpressure: hold out_ready low while offering stray beats that must not be taken.
        bus.out_ready = 1'b0;
        applyStimulus(packRow(1,1,1,1), packRow(1,1,1,1), packRow(1,1,1,1), packRow(1,1,1,1), 1'b0, 4);
        awaitBlock("hold");
        bus.in_valid = 1'b1;
        bus.in_row   = packRow(7,7,7,7);
        bus.in_mode  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("hold_valid", bus.out_valid, 1);
            checkOutput("hold_in_ready", bus.in_ready, 0);
            checkOutput("hold_c0", bus.coeff[0], 16);
            checkOutput("hold_c1", bus.coeff[1], 0);
            checkOutput("hold_mode", bus.out_mode, 0);
        end
        bus.in_valid  = 1'b0;
        bus.in_row    = '0;
        bus.out_ready = 1'b1;
        releaseBlock("hold");

        // If any stray beat had been taken, this impulse block would come out shifted or corrupted.
        applyStimulus(packRow(1,0,0,0), packRow(0,0,0,0), packRow(0,0,0,0), packRow(0,0,0,0), 1'b1, 4);
        awaitBlock("post_hold");
        expCoeff = '{1,2,1,1, 2,4,2,2, 1,2,1,1, 1,2,1,1};
        checkCoeffs("post_hold");
        checkOutput("post_hold_mode", bus.out_mode, 1);
        releaseBlock("post_hold");

        // Reset after three beats: the partial block must vanish and the next beat is row 0.
        applyStimulus(packRow(3,3,3,3), packRow(3,3,3,3), packRow(3,3,3,3), packRow(3,3,3,3), 1'b1, 3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checkOutput("midrst_no_valid", bus.out_valid, 0);
            checkOutput("midrst_in_ready", bus.in_ready, 1);
        end
        applyStimulus(packRow(1,1,1,1), packRow(1,1,1,1), packRow(1,1,1,1), packRow(1,1,1,1), 1'b0, 4);
        awaitBlock("midrst");
        setExpDc(16);
        checkCoeffs("midrst");
        checkOutput("midrst_mode", bus.out_mode, 0);
        releaseBlock("midrst");

        // Reset while a block waits in OUT: out_valid drops and the coefficients clear.
        bus.out_ready = 1'b0;
        applyStimulus(packRow(1,1,1,1), packRow(1,1,1,1), packRow(1,1,1,1), packRow(1,1,1,1), 1'b1, 4);
        awaitBlock("outrst");
        reset = 1'b1;
        @(negedge clk);
        checkOutput("outrst_valid", bus.out_valid, 0);
        checkOutput("outrst_in_ready", bus.in_ready, 1);
        checkOutput("outrst_c0", bus.coeff[0], 0);
        checkOutput("outrst_mode", bus.out_mode, 0);
        reset         = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);

`ifdef FWD_TX_HADAMARD_EN
        // Hadamard on a flat block of 2s: the DC term is 32, halved to 16.
        blockHad = 1'b1;
        applyStimulus(packRow(2,2,2,2), packRow(2,2,2,2), packRow(2,2,2,2), packRow(2,2,2,2), 1'b1, 4);
        awaitBlock("had_flat");
        setExpDc(16);
        checkCoeffs("had_flat");
        releaseBlock("had_flat");

        // Back-to-back blocks with the transform select alternating 0 / 1 / 0.
        // Core impulse of 2 gives 2*c[i]*c[j].
        blockHad = 1'b0;
        applyStimulus(packRow(2,0,0,0), packRow(0,0,0,0), packRow(0,0,0,0), packRow(0,0,0,0), 1'b0, 4);
        awaitBlock("alt_core");
        expCoeff = '{2,4,2,2, 4,8,4,4, 2,4,2,2, 2,4,2,2};
        checkCoeffs("alt_core");
        releaseBlock("alt_core");

        // Hadamard impulse of 2 spreads to 2 everywhere, which halves to 1.
        blockHad = 1'b1;
        applyStimulus(packRow(2,0,0,0), packRow(0,0,0,0), packRow(0,0,0,0), packRow(0,0,0,0), 1'b0, 4);
        awaitBlock("alt_had");
        for (int i = 0; i < 16; i++) expCoeff[i] = 1;
        checkCoeffs("alt_had");
        releaseBlock("alt_had");

        // The core transform again: the flat 2s give 32 with no halving.
        blockHad = 1'b0;
        applyStimulus(packRow(2,2,2,2), packRow(2,2,2,2), packRow(2,2,2,2), packRow(2,2,2,2), 1'b1, 4);
        awaitBlock("alt_core2");
        setExpDc(32);
        checkCoeffs("alt_core2");
        releaseBlock("alt_core2");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
